spi_bus_arbiter: RTL
====================

Name: spi_bus_arbiter

Overview:
- Shares one 16-bit SPI master engine (start/busy/done, 16-bit frame) between N on-chip requesters.
- Arbitration is round-robin. The block sequences one frame per grant and routes the received 16-bit word back to the granted requester.
- It sits between client logic (sensor pollers, config writers) and the SPI master. It also drives a slave-select index so the pad-level CS mux picks the right device.

Parameters:
- N, 4, number of requesters (2..8)
- IDX_W, 2, width of slave index, must equal ceil(log2(N))
- DW, 16, SPI frame width in bits
- TIMEOUT_CYC, 1024, max cycles in WAIT before abort (used only with SPI_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N  per-requester transaction request, level; held until matching done
- tx_data  in  N*DW  flat per-requester TX words, requester k at [k*DW +: DW]
- grant  out  N  one-hot, the requester currently owning the engine
- done  out  N  one-cycle pulse to the granted requester at end of frame
- rx_data  out  DW  last received word, valid with the done pulse, held until the next done
- err  out  1  one-cycle pulse with done when the frame was aborted by timeout
- m_start  out  1  one-cycle start strobe to the SPI master
- m_tx_data  out  DW  TX word for the SPI master, stable from m_start until m_done
- m_sel  out  IDX_W  slave index for the CS mux, stable while grant is nonzero
- m_done  in  1  SPI master end-of-frame pulse (one cycle)
- m_rx_data  in  DW  SPI master received word, valid when m_done=1

Behaviour:
- Reset values: grant=0, done=0, rx_data=0, err=0, m_start=0, m_tx_data=0, m_sel=0, state=IDLE.
  - The priority pointer resets so requester 0 has the highest priority.
- FSM states and transitions:
  - IDLE: if |req, select the winner w by round-robin; latch w, tx_data[w] into m_tx_data, m_sel=w; grant=onehot(w); go to ISSUE. Else stay.
  - ISSUE: m_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on m_done=1, latch m_rx_data into rx_data; go to DONE. m_done is sampled only in WAIT; m_done in any other state is ignored.
  - DONE: done[w]=1 for one cycle; grant cleared at the end of the cycle; pointer = (w+1) mod N; go to IDLE.
- Round-robin: search starts at the pointer and wraps from N-1 to 0. The first set req bit wins. A lone requester may win back-to-back.
- Latency:
  - req rises at cycle t (engine idle): grant at t+1, m_start at t+2.
  - m_done at cycle u: rx_data and done valid at u+1.
  - Minimum gap between frames: 2 cycles (DONE, IDLE).
- req dropped mid-frame: the frame is not aborted; done and rx_data are still produced.
- req held after done: treated as a new request and arbitrated in the next IDLE.
- tx_data changes after the grant cycle have no effect on the current frame.
- Simultaneous requests: exactly one grant; the others wait. No requester waits more than N-1 frames.
- rst_n asserted mid-frame: all outputs return to reset values immediately; no done pulse. The SPI master shares rst_n.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT. When it reaches TIMEOUT_CYC without m_done, go to DONE.
  - done[w]=1 and err=1 together; rx_data is unchanged; the pointer still advances.
  - The counter clears on every WAIT entry.
- Undefined:
  - No counter logic. WAIT holds indefinitely until m_done.
  - err is tied to 0.

Test Plan:
- Single requester: N=4, req=0001, tx_data[0]=16'hA50F, model answers m_rx_data=16'h00F0 after 16 SCK periods -> grant=0001 one cycle after req; m_start single pulse with m_tx_data=A50F, m_sel=0; done=0001 one pulse; rx_data=00F0.
- Round-robin fairness: req=1111 held for 8 frames -> grant order 0,1,2,3,0,1,2,3; each done pulse lands on the matching bit only.
- Mid-frame req drop: req[2] asserted, then deasserted one cycle after m_start -> frame completes; done[2] still pulses; no further grant to 2.
- Stray m_done: pulse m_done while in IDLE and in ISSUE -> no state change, no done, rx_data unchanged.
- Reset mid-frame: assert rst_n=0 during WAIT for 2 cycles -> grant=0 and m_start=0 immediately; after release, pointer at 0 and req=1010 grants requester 1 first.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYC=32, model never asserts m_done -> done[w] and err pulse together 32 cycles after WAIT entry; next pending requester granted afterwards.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master engine between N requesters.
// Optional WAIT-state abort timer is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
    parameter int N           = 4,
    parameter int IDX_W       = 2,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N*DW-1:0]   tx_data,
    output logic [N-1:0]      grant,
    output logic [N-1:0]      done,
    output logic [DW-1:0]     rx_data,
    output logic              err,
    output logic              m_start,
    output logic [DW-1:0]     m_tx_data,
    output logic [IDX_W-1:0]  m_sel,
    input  logic              m_done,
    input  logic [DW-1:0]     m_rx_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (IDX_W != $clog2(N) || N < 2 || N > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("spi_bus_arbiter: inconsistent parameters");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [N-1:0]     win_onehot;
    logic [IDX_W-1:0] ptr_next;
    logic             found;
    int               cand;

    // First set request at or after the pointer, wrapping from N-1 back to 0.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        win_onehot = N'(1) << win;
        ptr_next   = (m_sel == IDX_W'(N - 1)) ? '0 : m_sel + 1'b1;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int              TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant     <= '0;
            done      <= '0;
            rx_data   <= '0;
            m_start   <= 1'b0;
            m_tx_data <= '0;
            m_sel     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err       <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            m_start <= 1'b0;
            done    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (found) begin
                        m_sel     <= win;
                        m_tx_data <= tx_data[win*DW +: DW];
                        grant     <= win_onehot;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    m_start <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state   <= S_WAIT;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                S_WAIT: begin
                    if (m_done) begin
                        rx_data <= m_rx_data;
                        done    <= grant;
                        state   <= S_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Aborted frame: report it but keep the previous rx_data.
                        done    <= grant;
                        err     <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`else
                S_WAIT: begin
                    if (m_done) begin
                        rx_data <= m_rx_data;
                        done    <= grant;
                        state   <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    grant <= '0;
                    ptr   <= ptr_next;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef SPI_ARB_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule
